// File: rtl/ts4231_pkg.sv
// ---------------------------------------------------------------------------
// ts4231_pkg
// Shared definitions for the TS4231 configuration writer and reader blocks.
// Both blocks bit-bang the same E/D sensor pins, so they share the state
// naming, the configuration word width, the default configuration value
// and the pin-drive decode for each state.
// No ports (package).
// ---------------------------------------------------------------------------
package ts4231_pkg;

    localparam int CFG_BITS             = 15;
    localparam int TICK_DIV_DEFAULT     = 24;
    localparam int SETTLE_TICKS_DEFAULT = 4;
    localparam logic [CFG_BITS-1:0] DEFAULT_CFG = 15'h7256;

    // Bit-bang sequencer states, shared by writer and reader.
    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        READ_START,
        E_LOW,
        E_HIGH,
        STOP,
        STOP_D,
        WATCH_ELOW,
        WATCH_DLOW,
        WATCH_EHIGH
    } ts4231_state_t;

    // Drive values for the two sensor pins in one state.
    typedef struct packed {
        logic e_oe;
        logic e_out;
        logic d_oe;
        logic d_out;
    } ts4231_pins_t;

    // Pin drive for each state. Released pins keep e_out=1 / d_out=0 so the
    // released pattern is identical to the reset pattern.
    function automatic ts4231_pins_t pin_drive(input ts4231_state_t s);
        ts4231_pins_t p;
        p = '{e_oe: 1'b0, e_out: 1'b1, d_oe: 1'b0, d_out: 1'b0};
        case (s)
            READ_START:  p = '{e_oe: 1'b1, e_out: 1'b1, d_oe: 1'b1, d_out: 1'b0};
            E_LOW:       p = '{e_oe: 1'b1, e_out: 1'b0, d_oe: 1'b0, d_out: 1'b0};
            E_HIGH:      p = '{e_oe: 1'b1, e_out: 1'b1, d_oe: 1'b0, d_out: 1'b0};
            STOP:        p = '{e_oe: 1'b1, e_out: 1'b1, d_oe: 1'b1, d_out: 1'b0};
            STOP_D:      p = '{e_oe: 1'b1, e_out: 1'b1, d_oe: 1'b1, d_out: 1'b1};
            WATCH_ELOW:  p = '{e_oe: 1'b1, e_out: 1'b0, d_oe: 1'b1, d_out: 1'b1};
            WATCH_DLOW:  p = '{e_oe: 1'b1, e_out: 1'b0, d_oe: 1'b1, d_out: 1'b0};
            WATCH_EHIGH: p = '{e_oe: 1'b1, e_out: 1'b1, d_oe: 1'b1, d_out: 1'b0};
            default:     p = '{e_oe: 1'b0, e_out: 1'b1, d_oe: 1'b0, d_out: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ts4231_tick_gen.sv
// ---------------------------------------------------------------------------
// ts4231_tick_gen
// Free-running clock divider that produces the bit-bang tick. The counter
// runs 0..TICK_DIV-1 from reset and `tick` is high for the one clk in which
// the counter wraps.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out one-clk pulse every TICK_DIV clks
// ---------------------------------------------------------------------------
module ts4231_tick_gen #(
    parameter int TICK_DIV = 24
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: wraps to zero after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ts4231_config_reader.sv
// ---------------------------------------------------------------------------
// ts4231_config_reader
// Reads the configuration word back from a TS4231 over its bit-banged E/D
// pins (MSB first) and compares it against EXPECTED_CFG, confirming that an
// earlier configuration write took effect. Shares the sensor pins with the
// configuration writer through an external mux keyed on `busy`.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           readback request, acted on at its rising edge
//   enable          sensor configured; start ignored while low
//   busy            high from accepted start until done
//   done            one-clk pulse when the readback finishes
//   rd_data         last word read
//   match           rd_data == EXPECTED_CFG, valid from done onward
//   d_in/d_out/d_oe D pin input, drive value, output enable
//   e_in/e_out/e_oe E pin input (observation only), drive value, enable
// ---------------------------------------------------------------------------
module ts4231_config_reader #(
    parameter int TICK_DIV     = ts4231_pkg::TICK_DIV_DEFAULT,
    parameter int CFG_BITS     = ts4231_pkg::CFG_BITS,
    parameter logic [CFG_BITS-1:0] EXPECTED_CFG = ts4231_pkg::DEFAULT_CFG,
    parameter int SETTLE_TICKS = ts4231_pkg::SETTLE_TICKS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                enable,
    output logic                busy,
    output logic                done,
    output logic [CFG_BITS-1:0] rd_data,
    output logic                match,
    input  logic                d_in,
    output logic                d_out,
    output logic                d_oe,
    input  logic                e_in,
    output logic                e_out,
    output logic                e_oe
);

    import ts4231_pkg::*;

    localparam int IDX_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_TICKS - 1);

    ts4231_state_t  state;
    ts4231_state_t  state_next;
    ts4231_pins_t   pins;

    logic             tick;
    logic             start_q;
    logic             start_rise;
    logic             accept;
    logic             pending;
    logic             d_sync1;
    logic             d_sync2;
    logic [IDX_W-1:0] bit_idx;
    logic [SET_W-1:0] settle_cnt;
    logic             finish;
    logic             enter_read;

    // E is never read back; it is brought in so a debug probe can observe it.
    logic unused_e_in;
    assign unused_e_in = e_in;

    ts4231_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Input registers: start edge detector and the two-flop synchroniser
    // for the sensor-driven D pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            d_sync1 <= 1'b0;
            d_sync2 <= 1'b0;
        end else begin
            start_q <= start;
            d_sync1 <= d_in;
            d_sync2 <= d_sync1;
        end
    end

    // A start edge only counts when the block is idle and has no request
    // already waiting for a tick; anything else is dropped, not queued.
    assign start_rise = start & ~start_q;
    assign accept     = start_rise & enable & (state == IDLE) & ~busy;
    assign finish     = tick & (state == WATCH_EHIGH);
    assign enter_read = (state_next == READ_START) && (state != READ_START);

    // FSM state register; the state only moves on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and pin drive decode.
    always_comb begin
        state_next = state;
        pins       = pin_drive(state);
        if (tick) begin
            case (state)
                IDLE:        if (pending) state_next = SETTLE;
                SETTLE:      if (settle_cnt == SETTLE_LAST) state_next = READ_START;
                READ_START:  state_next = E_LOW;
                E_LOW:       state_next = E_HIGH;
                E_HIGH:      state_next = (bit_idx == '0) ? STOP : E_LOW;
                STOP:        state_next = STOP_D;
                STOP_D:      state_next = WATCH_ELOW;
                WATCH_ELOW:  state_next = WATCH_DLOW;
                WATCH_DLOW:  state_next = WATCH_EHIGH;
                WATCH_EHIGH: state_next = IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    assign e_oe  = pins.e_oe;
    assign e_out = pins.e_out;
    assign d_oe  = pins.d_oe;
    assign d_out = pins.d_out;

    // Request handshake: pending bridges the accepted edge to the next tick,
    // busy covers the whole transaction from the clk after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
            end else if (tick) begin
                pending <= 1'b0;
            end
            if (accept) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

    // Settle tick counter; held at zero outside SETTLE so every read gets
    // the full settle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state != SETTLE) begin
            settle_cnt <= '0;
        end else if (tick) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end
    end

    // Read datapath: clear the word as the read starts, then capture one
    // bit at the end of each E-high phase, MSB first. The index stops at
    // zero because the FSM leaves the bit loop there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            bit_idx <= '0;
        end else if (enter_read) begin
            rd_data <= '0;
            bit_idx <= IDX_W'(CFG_BITS - 1);
        end else if (tick && (state == E_HIGH)) begin
            rd_data[bit_idx] <= d_sync2;
            if (bit_idx != '0) begin
                bit_idx <= bit_idx - IDX_W'(1);
            end
        end
    end

    // Completion: done pulses for one clk and match is refreshed from the
    // finished word, then held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            match <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                match <= (rd_data == EXPECTED_CFG);
            end
        end
    end

endmodule

// File: tb/tb_ts4231_config_reader.sv
// ---------------------------------------------------------------------------
// tb_ts4231_config_reader
// Self-checking bench for ts4231_config_reader. A sensor model answers the
// E/D read protocol with a chosen word; every accepted request pushes its
// expected word, match flag and completion cycle into a scoreboard that a
// separate monitor pops on each done pulse. A pin monitor checks the E/D
// drive order of every completed transaction.
// ---------------------------------------------------------------------------
module tb_ts4231_config_reader;

    localparam int TICK_DIV     = 24;
    localparam int NBITS        = 15;
    localparam int SETTLE_TICKS = 4;
    localparam logic [NBITS-1:0] EXP_CFG = 15'h7256;
    localparam int READ_TICKS   = SETTLE_TICKS + 1 + 2 * NBITS + 5;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             start  = 1'b0;
    logic             enable = 1'b0;
    logic             d_in   = 1'b0;
    logic             e_in;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] rd_data;
    logic             match;
    logic             d_out;
    logic             d_oe;
    logic             e_out;
    logic             e_oe;

    ts4231_config_reader #(
        .TICK_DIV     (TICK_DIV),
        .CFG_BITS     (NBITS),
        .EXPECTED_CFG (EXP_CFG),
        .SETTLE_TICKS (SETTLE_TICKS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .enable  (enable),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .match   (match),
        .d_in    (d_in),
        .d_out   (d_out),
        .d_oe    (d_oe),
        .e_in    (e_in),
        .e_out   (e_out),
        .e_oe    (e_oe)
    );

    always #5 clk = ~clk;

    // E line with a pull-up when nobody drives it.
    assign e_in = e_oe ? e_out : 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_pushed = 0;

    // Clock edges since reset release; equals the divider phase of the DUT.
    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [NBITS-1:0] word;
        logic             exp_match;
        int unsigned      done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(mon_e.word));
                checkOutput("match", 32'(match), 32'(mon_e.exp_match));
                checkOutput("done_cycle", cyc, mon_e.done_cyc);
            end
        end
    end

    // ---------------- sensor model ----------------
    // Presents the next word bit on D at each E falling edge while D is
    // released, counting bits from the start of each transaction.
    logic [NBITS-1:0] sensor_word = '0;
    int               sensor_bit = 0;
    logic             sens_prev_eoe  = 1'b0;
    logic             sens_prev_eout = 1'b1;

    always @(negedge clk) begin
        if (e_oe && !sens_prev_eoe) sensor_bit = 0;
        if (e_oe && !e_out && sens_prev_eout && !d_oe && sensor_bit < NBITS) begin
            d_in = sensor_word[NBITS-1-sensor_bit];
            sensor_bit++;
        end
        sens_prev_eoe  = e_oe;
        sens_prev_eout = e_out;
    end

    // ---------------- pin-order monitor ----------------
    // Pin code {e_oe, E driven value, d_oe, D driven value}; 0 = released.
    logic [3:0] tr_q[$];
    logic [3:0] tr_exp[$];
    logic [3:0] tr_prev = 4'b0000;
    logic [3:0] tr_cur;
    int         tr_mism;
    int         tr_busy_bad = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tr_q.delete();
            tr_prev     = 4'b0000;
            tr_busy_bad = 0;
        end else begin
            tr_cur = {e_oe, e_oe & e_out, d_oe, d_oe & d_out};
            if (tr_cur != 4'b0000 && !busy) tr_busy_bad++;
            if (tr_cur != tr_prev) begin
                if (tr_cur == 4'b0000) begin
                    checkOutput("pin_seq_len", tr_q.size(), tr_exp.size());
                    tr_mism = 0;
                    for (int i = 0; i < tr_q.size() && i < tr_exp.size(); i++)
                        if (tr_q[i] != tr_exp[i]) tr_mism++;
                    checkOutput("pin_seq_order", tr_mism, 0);
                    checkOutput("busy_while_pins_driven", tr_busy_bad, 0);
                    tr_q.delete();
                    tr_busy_bad = 0;
                end else begin
                    if (tr_cur == 4'b1000 && tr_q.size() == 1)
                        checkOutput("rd_data_cleared_at_read_start", 32'(rd_data), 32'd0);
                    tr_q.push_back(tr_cur);
                end
            end
            tr_prev = tr_cur;
        end
    end

    // ---------------- stimulus ----------------
    // Issues one start pulse. phase >= 0 places the detecting clk edge at
    // that divider phase; immediate skips the initial clk wait. Ticks land
    // on edges that are multiples of TICK_DIV, so an edge detected at k is
    // consumed by the next multiple above k and done follows READ_TICKS
    // ticks later.
    task automatic applyStimulus(input logic [NBITS-1:0] word, input logic en,
                                 input int phase, input bit immediate);
        exp_t        e;
        int unsigned k;
        bit          accept_model;
        if (!immediate) begin
            @(negedge clk);
            #1;
        end
        while (phase >= 0 && int'((cyc + 1) % TICK_DIV) != phase) begin
            @(negedge clk);
            #1;
        end
        enable       = en;
        accept_model = en && (sb_q.size() == 0);
        k            = cyc + 1;
        if (accept_model) begin
            sensor_word = word;
            e.word      = word;
            e.exp_match = (word == EXP_CFG);
            e.done_cyc  = (k / TICK_DIV + 1) * TICK_DIV + READ_TICKS * TICK_DIV;
            sb_q.push_back(e);
            n_pushed++;
        end
        start = 1'b1;
        @(negedge clk);
        if (accept_model) checkOutput("busy_after_accept", 32'(busy), 32'd1);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            timeoutFail("wait_done");
            n_pushed = n_pushed - sb_q.size();
            sb_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int               bad;
        int               guard;
        int               cnt;
        logic [3:0]       pc;
        logic [3:0]       cc;
        logic [NBITS-1:0] w;
        logic             en;

        tr_exp.push_back(4'b1110);
        for (int i = 0; i < NBITS; i++) begin
            tr_exp.push_back(4'b1000);
            tr_exp.push_back(4'b1100);
        end
        tr_exp.push_back(4'b1110);
        tr_exp.push_back(4'b1111);
        tr_exp.push_back(4'b1011);
        tr_exp.push_back(4'b1010);
        tr_exp.push_back(4'b1110);

        // Reset values.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
        checkOutput("reset_match", 32'(match), 32'd0);
        checkOutput("reset_pins", 32'({e_oe, e_out, d_oe, d_out}), 32'b0100);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] start with enable low is ignored");
        applyStimulus(15'h1234, 1'b0, -1, 1'b0);
        bad = 0;
        repeat (2000) begin
            @(negedge clk);
            if (busy || e_oe || d_oe) bad++;
        end
        checkOutput("ignored_when_disabled", bad, 0);
        checkOutput("no_done_when_disabled", n_done, 0);

        $display("[TB] golden readback");
        applyStimulus(EXP_CFG, 1'b1, -1, 1'b0);
        waitIdle(1500);

        $display("[TB] off-by-one word, second edge while busy, enable drop");
        applyStimulus(15'h7257, 1'b1, -1, 1'b0);
        repeat (150) @(negedge clk);
        enable = 1'b0;
        repeat (100) @(negedge clk);
        applyStimulus(15'h0ABC, 1'b1, -1, 1'b0);
        waitIdle(1500);
        checkOutput("single_done_per_read", n_done, 2);

        $display("[TB] start edge one clk before a tick");
        applyStimulus(15'h5A5A, 1'b1, TICK_DIV - 1, 1'b0);
        waitIdle(1500);

        $display("[TB] back-to-back reads");
        applyStimulus(15'h0000, 1'b1, -1, 1'b0);
        waitIdle(1500);
        applyStimulus(15'h7FFF, 1'b1, -1, 1'b1);
        waitIdle(1500);

        $display("[TB] randomized requests");
        for (int i = 0; i < 8; i++) begin
            w  = NBITS'($urandom);
            if ($urandom_range(0, 3) == 0) w = EXP_CFG;
            en = ($urandom_range(0, 6) != 0);
            repeat ($urandom_range(0, 50)) @(negedge clk);
            applyStimulus(w, en, -1, 1'b0);
            waitIdle(1500);
        end

        $display("[TB] reset during E_HIGH of bit 7");
        applyStimulus(15'h2C3D, 1'b1, -1, 1'b0);
        cnt   = 0;
        guard = 0;
        pc    = 4'b0000;
        while (cnt < 8 && guard < 3000) begin
            @(negedge clk);
            guard++;
            cc = {e_oe, e_oe & e_out, d_oe, d_oe & d_out};
            if (cc == 4'b1100 && pc != 4'b1100) cnt++;
            pc = cc;
        end
        if (cnt < 8) timeoutFail("reach_bit7");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_d_oe", 32'(d_oe), 32'd0);
        checkOutput("midreset_e_oe", 32'(e_oe), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_e_out", 32'(e_out), 32'd1);
        checkOutput("midreset_rd_data", 32'(rd_data), 32'd0);
        n_pushed = n_pushed - sb_q.size();
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(EXP_CFG, 1'b1, -1, 1'b0);
        waitIdle(1500);

        repeat (50) @(negedge clk);
        checkOutput("done_count", n_done, n_pushed);
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
